// File: rtl/branch_pkg.sv
// branch_pkg -- shared opcode constants for the branch/return-stack block.
//
// Contents:
//   OPC_MSB/OPC_LSB : position of the opcode field inside instr
//   opcode_t        : decoded branch opcodes (OP_JR, OP_JPC, OP_CALL, OP_RET)
//
// Build option: BRANCH_RAS_WRAP_EN (used by ras_lifo) selects a circular
// return stack that overwrites its oldest entry when a CALL arrives while full.
package branch_pkg;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    typedef enum logic [OPC_W-1:0] {
        OP_JR   = 5'b01101,
        OP_JPC  = 5'b01110,
        OP_CALL = 5'b10000,
        OP_RET  = 5'b10001
    } opcode_t;

endpackage

// File: rtl/ras_lifo.sv
// ras_lifo -- return-address stack (LIFO) used by branch_ctrl_ras.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (pointer/count only)
//   flush          : synchronous clear of pointer and count
//   push/push_data : store a return address
//   pop            : discard the top entry
//   top_data       : current top entry (meaningless while empty)
//   count          : occupancy, 0..DEPTH
//   full, empty    : decoded combinationally from count
//
// Build option: BRANCH_RAS_WRAP_EN -- push while full overwrites the oldest
// entry (circular); otherwise a push while full is dropped.
module ras_lifo #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        push_data,
    output logic [ADDR_W-1:0]        top_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Storage carries no reset; entries are only visible through top_data
    // when count is non-zero.
    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_sp;      // next free slot; top lives at r_sp-1
    logic [CW-1:0]     r_count;

    logic              w_wr;
    logic              w_rd;
    logic [PW-1:0]     w_top_idx;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_top_idx = r_sp - PW'(1);
    assign top_data  = r_mem[w_top_idx];

`ifdef BRANCH_RAS_WRAP_EN
    // When full, r_sp points at the oldest entry, so a plain write at r_sp
    // followed by increment overwrites it and keeps LIFO order of the newest.
    assign w_wr = push && !flush;
`else
    assign w_wr = push && !flush && !full;
`endif
    assign w_rd = pop && !flush && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (w_wr) begin
            r_sp <= r_sp + PW'(1);
            if (!full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (w_rd) begin
            r_sp    <= r_sp - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_sp] <= push_data;
        end
    end

endmodule

// File: rtl/branch_ctrl_ras.sv
// branch_ctrl_ras -- branch target unit with return-address stack.
//
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   en             : instr valid this cycle
//   flush          : clears the stack and error flags; wins over en
//   instr          : opcode in instr[31:27] (JR, JPC, CALL, RET)
//   addr           : return address pushed by CALL
//   rd, immediate  : target operands
//   r_abs, taken   : registered target and one-cycle taken pulse
//   full, empty, count : stack occupancy
//   ovf, unf       : sticky overflow / underflow flags
//
// Build option: BRANCH_RAS_WRAP_EN -- CALL while full overwrites the oldest
// entry and never raises ovf.
module branch_ctrl_ras
    import branch_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        instr,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        rd,
    input  logic [DATA_W-1:0]        immediate,
    output logic [DATA_W-1:0]        r_abs,
    output logic                     taken,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     unf
);

    logic [OPC_W-1:0]  w_opc;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_top;
    logic              w_unused;

    assign w_opc    = instr[OPC_MSB:OPC_LSB];
    assign w_unused = ^instr;
    assign w_push   = en && !flush && (w_opc == OP_CALL);
    assign w_pop    = en && !flush && (w_opc == OP_RET);

    ras_lifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (flush),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (addr),
        .top_data  (w_top),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_abs <= '0;
            taken <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (flush) begin
            taken <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (en) begin
            case (w_opc)
                OP_JR: begin
                    r_abs <= rd;
                    taken <= 1'b1;
                end
                OP_JPC: begin
                    r_abs <= rd + immediate + DATA_W'(1);
                    taken <= 1'b1;
                end
                OP_CALL: begin
                    r_abs <= rd;
                    taken <= 1'b1;
`ifndef BRANCH_RAS_WRAP_EN
                    if (full) begin
                        ovf <= 1'b1;
                    end
`endif
                end
                OP_RET: begin
                    taken <= 1'b1;
                    if (empty) begin
                        r_abs <= '0;
                        unf   <= 1'b1;
                    end else begin
                        r_abs <= DATA_W'(w_top);
                    end
                end
                default: begin
                    taken <= 1'b0;
                end
            endcase
        end else begin
            taken <= 1'b0;
        end
    end

endmodule
